// File: rtl/osc_reset_sequencer.sv
// osc_reset_sequencer: holds the fabric PLL in reset, qualifies a stable lock, then releases the fabric reset with bounded retries
module osc_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 160000,
    parameter int RELEASE_DELAY       = 256,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 18
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       SW_RESET_REQ,
    output logic       PLL_ARST,
    output logic       FABRIC_RESET,
    output logic       READY,
    output logic       FAIL,
    output logic [2:0] STATE,
    output logic [1:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);
    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_N     = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RELEASE_DELAY - 1);
    localparam logic [CNT_W-1:0] RETRY_MAX    = CNT_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

    state_t           state;
    logic             lock_m;
    logic             lock_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] stable;
    logic [CNT_W-1:0] retry_next;

    assign STATE      = state;
    assign retry_next = CNT_W'(RETRY_CNT) + ONE;

    // two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= PLL_LOCK;
            lock_s <= lock_m;
        end
    end

    // sequencer: cnt times RST_PLL, the lock timeout and HOLD; stable counts consecutive lock cycles
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_RST_PLL;
            cnt          <= '0;
            stable       <= '0;
            PLL_ARST     <= 1'b1;
            FABRIC_RESET <= 1'b1;
            READY        <= 1'b0;
            FAIL         <= 1'b0;
            RETRY_CNT    <= 2'd0;
            LOSS_CNT     <= 8'd0;
        end else begin
            case (state)
                ST_RST_PLL: begin
                    if (cnt == RST_LAST) begin
                        state    <= ST_WAIT_LOCK;
                        cnt      <= '0;
                        stable   <= '0;
                        PLL_ARST <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (stable == STABLE_N) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt      <= '0;
                        PLL_ARST <= 1'b1;
                        if (retry_next < RETRY_MAX) begin
                            state     <= ST_RST_PLL;
                            RETRY_CNT <= (RETRY_CNT == 2'd3) ? RETRY_CNT : RETRY_CNT + 2'd1;
                        end else begin
                            state <= ST_FAIL;
                            FAIL  <= 1'b1;
                        end
                    end else begin
                        cnt    <= cnt + ONE;
                        stable <= lock_s ? stable + ONE : '0;
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        state    <= ST_RST_PLL;
                        cnt      <= '0;
                        PLL_ARST <= 1'b1;
                    end else if (cnt == HOLD_LAST) begin
                        state        <= ST_RUN;
                        cnt          <= '0;
                        FABRIC_RESET <= 1'b0;
                        READY        <= 1'b1;
                        RETRY_CNT    <= 2'd0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s || SW_RESET_REQ) begin
                        state        <= ST_RST_PLL;
                        cnt          <= '0;
                        PLL_ARST     <= 1'b1;
                        FABRIC_RESET <= 1'b1;
                        READY        <= 1'b0;
                        if (!lock_s && LOSS_CNT != 8'hFF) LOSS_CNT <= LOSS_CNT + 8'd1;
                    end
                end
                ST_FAIL: begin
                    state <= ST_FAIL;
                end
                default: begin
                    state        <= ST_RST_PLL;
                    cnt          <= '0;
                    PLL_ARST     <= 1'b1;
                    FABRIC_RESET <= 1'b1;
                    READY        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_osc_reset_sequencer.sv
// tb_osc_reset_sequencer: directed vector table, corner sequences and random stimulus against a timestamp-based reference model
module tb_osc_reset_sequencer;
    localparam int PRC  = 4;
    localparam int LSC  = 8;
    localparam int LTC  = 50;
    localparam int RD   = 5;
    localparam int MAXR = 2;
    localparam int HN   = 65536;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       sw = 1'b0;
    logic       arst, frst, rdy, fl;
    logic [2:0] st;
    logic [1:0] rc;
    logic [7:0] lc;

    int errors = 0;
    int checks = 0;

    osc_reset_sequencer #(
        .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(LTC),
        .RELEASE_DELAY(RD), .MAX_RETRIES(MAXR), .CNT_W(18)
    ) dut (
        .CLK(clk), .RESET(rst), .PLL_LOCK(lock), .SW_RESET_REQ(sw),
        .PLL_ARST(arst), .FABRIC_RESET(frst), .READY(rdy), .FAIL(fl),
        .STATE(st), .RETRY_CNT(rc), .LOSS_CNT(lc)
    );

    always #5 clk = ~clk;

    // reference model: phase plus entry timestamp; the stable-lock run is recounted from a sample history
    int n = 0, last_rst = -10, m_ph = 1, m_start = 0, m_retry = 0, m_loss = 0, run = 0;
    bit m_valid = 1'b0;
    bit ls;
    bit samp[HN];
    bit lsh[HN];

    always @(posedge clk) begin
        n = n + 1;
        samp[n] = lock;
        ls = (n >= 3 && n - last_rst >= 3) ? samp[n-2] : 1'b0;
        lsh[n] = ls;
        if (rst) begin
            m_valid = 1'b1; last_rst = n; m_ph = 1; m_start = n; m_retry = 0; m_loss = 0;
        end else begin
            case (m_ph)
                1: if (n - m_start == PRC) begin m_ph = 2; m_start = n; end
                2: begin
                    run = 0;
                    for (int k = n - 1; k > m_start && lsh[k]; k--) run++;
                    if (run == LSC) begin
                        m_ph = 3; m_start = n;
                    end else if (n - m_start == LTC) begin
                        if (m_retry + 1 < MAXR) begin m_retry++; m_ph = 1; end
                        else m_ph = 5;
                        m_start = n;
                    end
                end
                3: if (!ls) begin m_ph = 1; m_start = n; end
                   else if (n - m_start == RD) begin m_ph = 4; m_retry = 0; m_start = n; end
                4: if (!ls || sw) begin
                       if (!ls && m_loss < 255) m_loss++;
                       m_ph = 1; m_start = n;
                   end
                default: ;
            endcase
        end
    end

    // every cycle after the first reset, the DUT must match the model
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({st, arst, frst, rdy, fl, rc, lc} !==
                {3'(m_ph), (m_ph == 1 || m_ph == 5), (m_ph != 4), (m_ph == 4), (m_ph == 5), 2'(m_retry), 8'(m_loss)}) begin
                errors++;
                $display("FAIL model t=%0t got st=%0d arst=%b frst=%b rdy=%b fail=%b rc=%0d lc=%0d want st=%0d rc=%0d lc=%0d",
                         $time, st, arst, frst, rdy, fl, rc, lc, m_ph, m_retry, m_loss);
            end
        end
    end

    typedef struct packed {
        logic r, l, s;
        logic [7:0] n;
        logic [2:0] st;
        logic arst, fr, rdy, fl;
        logic [1:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, l, s, input int cyc_n, st_e,
                               input logic a, f, y, x, input int rc_e, lc_e);
        v = {r, l, s, 8'(cyc_n), 3'(st_e), a, f, y, x, 2'(rc_e), 8'(lc_e)};
    endfunction

    task automatic cyc(input logic r, input logic l, input logic s, input int k);
        for (int i = 0; i < k; i++) begin
            rst = r; lock = l; sw = s;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        //              r  l  s  n   st arst fr rdy fl rc lc
        tbl.push_back(v(1, 0, 0, 2,  1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3,  1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1,  2, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 49, 2, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1,  1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 3,  1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1,  2, 0, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 49, 2, 0, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1,  5, 1, 1, 0, 1, 1, 0));
        tbl.push_back(v(0, 1, 1, 20, 5, 1, 1, 0, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 4,  2, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 10, 2, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1,  3, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 4,  3, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1,  4, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1,  4, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1,  4, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1,  1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 4,  2, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 8,  2, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 1,  3, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 5,  4, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 1, 1, 1,  1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 18, 4, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 2,  4, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 1,  1, 1, 1, 0, 0, 0, 2));
        tbl.push_back(v(0, 0, 0, 4,  2, 0, 1, 0, 0, 0, 2));
        tbl.push_back(v(0, 0, 1, 1,  2, 0, 1, 0, 0, 0, 2));
        tbl.push_back(v(0, 1, 0, 10, 2, 0, 1, 0, 0, 0, 2));
        tbl.push_back(v(0, 1, 0, 1,  3, 0, 1, 0, 0, 0, 2));
        tbl.push_back(v(1, 1, 0, 1,  1, 1, 1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].l, tbl[i].s, int'(tbl[i].n));
            checks++;
            if ({st, arst, frst, rdy, fl, rc, lc} !==
                {tbl[i].st, tbl[i].arst, tbl[i].fr, tbl[i].rdy, tbl[i].fl, tbl[i].rc, tbl[i].lc}) begin
                errors++;
                $display("FAIL vec%0d got st=%0d arst=%b frst=%b rdy=%b fail=%b rc=%0d lc=%0d want st=%0d arst=%b frst=%b rdy=%b fail=%b rc=%0d lc=%0d",
                         i, st, arst, frst, rdy, fl, rc, lc, tbl[i].st, tbl[i].arst, tbl[i].fr,
                         tbl[i].rdy, tbl[i].fl, tbl[i].rc, tbl[i].lc);
            end
        end

        // lock glitch shorter than the stable window, then steady lock timed from its last rise
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 4);
        cyc(0, 1, 0, 5);
        cyc(0, 0, 0, 3);
        chk("glitch_no_hold", int'(st), 2);
        t = 0;
        do begin
            cyc(0, 1, 0, 1);
            t++;
        end while (frst && t < 40);
        chk("release_after_last_rise", t, 2 + LSC + RD + 1);

        // repeated lock losses: LOSS_CNT saturates at 255
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 256; i++) begin
            k = 0;
            while (!rdy && k < 60) begin
                cyc(0, 1, 0, 1);
                k++;
            end
            if (!rdy) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout iter=%0d got ready=%b want 1", i, rdy);
                break;
            end
            cyc(0, 0, 0, 1);
            cyc(0, 1, 0, 3);
            if (i == 254) chk("loss_255", int'(lc), 255);
        end
        chk("loss_saturated", int'(lc), 255);

        // random lock, request and reset activity checked against the model every cycle
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 3000;) begin
            logic l;
            int dur;
            l = ($urandom_range(0, 3) != 0);
            dur = $urandom_range(0, 1) ? $urandom_range(1, 12) : $urandom_range(1, 120);
            for (int j = 0; j < dur; j++) begin
                cyc(($urandom_range(0, 399) == 0), l, ($urandom_range(0, 29) == 0), 1);
                i++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
